systolic_pe: RTL

- Single processing element of the systolic matrix-multiply array.
- Sits directly downstream of the skew delay FIFOs. The west edge consumes the A-row skew line outputs; the north edge consumes the B-column skew line outputs.
- Multiply-accumulates matched (a, b) pairs and forwards both operands east/south with one cycle of delay to the next PE.
- After K_DEPTH accepted pairs, presents the dot-product result and restarts accumulation.

---
 rtl/sma_pkg.sv | 15 +
 rtl/systolic_pe.sv | 83 ++++++++
 2 files changed

// File: rtl/sma_pkg.sv
// Shared constants and helpers for the systolic matrix-multiply array.
// Used by the skew FIFOs, the PEs and the array top.
package sma_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ARRAY_ROWS = 4;
  localparam int ARRAY_COLS = 4;
  localparam int ARRAY_K    = 4;

  // Counter width able to hold the value k itself.
  function automatic int cntWidth(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// Systolic processing element: forwards operands east/south with one cycle
// of delay and accumulates K_DEPTH matched pairs into a held dot product.
module systolic_pe
  import sma_pkg::*;
#(
  parameter int WIDTH   = DATA_WIDTH,
  parameter int K_DEPTH = ARRAY_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] a_in,
  input  logic             a_in_valid,
  input  logic [WIDTH-1:0] b_in,
  input  logic             b_in_valid,
  output logic [WIDTH-1:0] a_out,
  output logic             a_out_valid,
  output logic [WIDTH-1:0] b_out,
  output logic             b_out_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             protocol_error
);

  localparam int            CW   = cntWidth(K_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(K_DEPTH - 1);

  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic             a_valid_q, b_valid_q, result_valid_q, perr_q;
  logic [CW-1:0]    cnt_q;

  logic             fire_d;
  logic [WIDTH-1:0] prod_d, sum_d;

  // A fresh dot product starts from zero rather than the stale accumulator.
  assign fire_d = a_in_valid && b_in_valid && !clear;
  assign prod_d = a_in * b_in;
  assign sum_d  = ((cnt_q == '0) ? '0 : acc_q) + prod_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q            <= '0;
      b_q            <= '0;
      a_valid_q      <= 1'b0;
      b_valid_q      <= 1'b0;
      acc_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      a_q            <= a_in;
      b_q            <= b_in;
      a_valid_q      <= a_in_valid;
      b_valid_q      <= b_in_valid;
      result_valid_q <= 1'b0;
      if (a_in_valid != b_in_valid) perr_q <= 1'b1;
      if (clear) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else if (fire_d) begin
        if (cnt_q == LAST) begin
          result_q       <= sum_d;
          result_valid_q <= 1'b1;
          acc_q          <= '0;
          cnt_q          <= '0;
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign a_out          = a_q;
  assign a_out_valid    = a_valid_q;
  assign b_out          = b_q;
  assign b_out_valid    = b_valid_q;
  assign result         = result_q;
  assign result_valid   = result_valid_q;
  assign protocol_error = perr_q;

endmodule
